// File: rtl/calc_sched.sv
// Round-robin scheduler that shares one 8-bit calculator ALU among NREQ requesters.
// Optional illegal-op error flag: define CALC_SCHED_ERR_EN to add the err port.
//
// state  | meaning
// S_IDLE | waiting for any req; picks the ptr-ordered winner and latches its operands
// S_EXEC | counting down the op latency; result and done are loaded when cnt hits 0
// S_DONE | done pulse cycle; drops grant and advances ptr past the served requester
module calc_sched #(
  parameter int NREQ       = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   op,
  input  logic [8*NREQ-1:0]   a,
  input  logic [8*NREQ-1:0]   b,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [7:0]          result,
`ifdef CALC_SCHED_ERR_EN
  output logic                busy,
  output logic                err
`else
  output logic                busy
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_win, w_win_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_op, w_op_nxt;
  logic [7:0]      r_a, w_a_nxt;
  logic [7:0]      r_b, w_b_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [7:0]      r_result, w_result_nxt;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;
  logic [2:0]      w_sel_op;
  logic [7:0]      w_sel_a;
  logic [7:0]      w_sel_b;
  logic [7:0]      w_alu;

`ifdef CALC_SCHED_ERR_EN
  logic            r_err, w_err_nxt;
  logic            w_illegal;
  assign w_illegal = r_op[2] & r_op[1];
  assign err       = r_err;
`endif

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign result = r_result;
  assign busy   = (r_state != S_IDLE);

  // Rotating priority: scan from ptr upward, wrapping at NREQ-1.
  always_comb begin : winner_sel
    logic [PW-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
      idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_win_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_win == PW'(j)) begin
        w_sel_op    = op[3*j +: 3];
        w_sel_a     = a[8*j +: 8];
        w_sel_b     = b[8*j +: 8];
        w_win_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      3'd0:    w_alu = r_a * r_b;
      3'd1:    w_alu = r_a + r_b;
      3'd2:    w_alu = r_a - r_b;
      3'd3:    w_alu = r_a * r_a;
      3'd4:    w_alu = r_a + 8'd1;
      3'd5:    w_alu = r_a - 8'd1;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_win_nxt    = r_win;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_result_nxt = r_result;
`ifdef CALC_SCHED_ERR_EN
    w_err_nxt    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_win_nxt   = w_win;
          w_op_nxt    = w_sel_op;
          w_a_nxt     = w_sel_a;
          w_b_nxt     = w_sel_b;
          w_gnt_nxt   = w_win_oh;
          w_cnt_nxt   = (w_sel_op == 3'd0 || w_sel_op == 3'd3) ? CW'(MUL_CYCLES - 1) : '0;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_done_nxt  = r_gnt;
          w_state_nxt = S_DONE;
`ifdef CALC_SCHED_ERR_EN
          // Illegal ops flag err and leave the previous result visible.
          if (w_illegal) w_err_nxt = 1'b1;
          else           w_result_nxt = w_alu;
`else
          w_result_nxt = w_alu;
`endif
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_gnt_nxt   = '0;
        w_ptr_nxt   = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_win    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
`ifdef CALC_SCHED_ERR_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_win    <= w_win_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
`ifdef CALC_SCHED_ERR_EN
      r_err    <= w_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// Self-checking bench for calc_sched (NREQ=4, MUL_CYCLES=3): table-driven single jobs
// plus hand sequences for reset, round-robin order, mid-job reset and illegal ops.
module tb_calc_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        busy;
`ifdef CALC_SCHED_ERR_EN
  logic        err;
`endif

  int n_pass = 0;
  int n_tot  = 0;
  int viol   = 0;

  calc_sched #(.NREQ(4), .MUL_CYCLES(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op     (op),
    .a      (a),
    .b      (b),
    .gnt    (gnt),
    .done   (done),
    .result (result),
`ifdef CALC_SCHED_ERR_EN
    .busy   (busy),
    .err    (err)
`else
    .busy   (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant and done must stay one-hot-or-zero, and done only where gnt is set.
  always @(negedge clk) begin
    if ($countones(gnt) > 1 || $countones(done) > 1 || (done & ~gnt) != 4'b0) viol++;
  end

  typedef struct {
    int         idx;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_in(input int idx, input logic [2:0] o, input logic [7:0] va,
                        input logic [7:0] vb);
    op[3*idx +: 3] = o;
    a[8*idx +: 8]  = va;
    b[8*idx +: 8]  = vb;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One job from a lone requester; operands are scrambled after grant to prove latching.
  task automatic run_job(input string nm, input int idx, input logic [2:0] o,
                         input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] exp_res, input int exp_lat);
    int lat;
    set_in(idx, o, va, vb);
    req = 4'b0001 << idx;
    tick();
    chk({nm, "_gnt"}, {28'b0, gnt}, 32'(1 << idx));
    set_in(idx, o ^ 3'b001, ~va, ~vb);
    lat = 0;
    while (done == 4'b0 && lat < 10) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_done"}, {28'b0, done}, 32'(1 << idx));
    chk({nm, "_result"}, {24'b0, result}, {24'b0, exp_res});
    req = '0;
    tick();
    chk({nm, "_done_clr"}, {28'b0, done}, 32'd0);
    chk({nm, "_gnt_clr"}, {28'b0, gnt}, 32'd0);
    tick();
  endtask

  initial begin
    int cnt;
    logic [7:0] prev;
    vecs[0] = '{idx: 0, op: 3'd1, a: 8'd200, b: 8'd100, res: 8'd44,  lat: 1};
    vecs[1] = '{idx: 1, op: 3'd0, a: 8'd12,  b: 8'd11,  res: 8'd132, lat: 3};
    vecs[2] = '{idx: 1, op: 3'd3, a: 8'd16,  b: 8'd99,  res: 8'd0,   lat: 3};
    vecs[3] = '{idx: 2, op: 3'd2, a: 8'd5,   b: 8'd10,  res: 8'd251, lat: 1};
    vecs[4] = '{idx: 3, op: 3'd4, a: 8'd255, b: 8'd7,   res: 8'd0,   lat: 1};
    vecs[5] = '{idx: 0, op: 3'd5, a: 8'd0,   b: 8'd3,   res: 8'd255, lat: 1};
    vecs[6] = '{idx: 2, op: 3'd0, a: 8'd200, b: 8'd3,   res: 8'd88,  lat: 3};

    op = '0;
    a  = '0;
    b  = '0;
    do_reset();
    chk("rst_gnt", {28'b0, gnt}, 32'd0);
    chk("rst_done", {28'b0, done}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    chk("idle_gnt", {28'b0, gnt}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    for (int v = 0; v < 7; v++)
      run_job($sformatf("vec%0d", v), vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b,
              vecs[v].res, vecs[v].lat);

    // Round robin with all four requesting op=4, a=i.
    do_reset();
    for (int i = 0; i < 4; i++) set_in(i, 3'd4, 8'(i), 8'd0);
    req = 4'b1111;
    tick();
    chk("rr_gnt0", {28'b0, gnt}, 32'd1);
    chk("rr_busy", {31'b0, busy}, 32'd1);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("rr_done%0d", g), {28'b0, done}, 32'(1 << g));
      chk($sformatf("rr_res%0d", g), {24'b0, result}, 32'(g + 1));
      tick();
      chk($sformatf("rr_gap%0d", g), {28'b0, gnt}, 32'd0);
      tick();
      chk($sformatf("rr_gnt%0d", g + 1), {28'b0, gnt}, 32'(1 << ((g + 1) % 4)));
    end
    req = '0;
    tick();
    tick();
    tick();

    // Reset in the 2nd EXEC cycle of a mul, with ptr parked at 3.
    do_reset();
    run_job("pre", 2, 3'd4, 8'd2, 8'd0, 8'd3, 1);
    set_in(3, 3'd0, 8'd12, 8'd11);
    req = 4'b1000;
    tick();
    chk("mr_gnt", {28'b0, gnt}, 32'd8);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = '0;
    chk("mr_gnt0", {28'b0, gnt}, 32'd0);
    chk("mr_result0", {24'b0, result}, 32'd0);
    chk("mr_busy0", {31'b0, busy}, 32'd0);
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (done != 4'b0) cnt++;
    end
    chk("mr_no_done", cnt, 0);
    for (int i = 0; i < 4; i++) set_in(i, 3'd4, 8'(i), 8'd0);
    req = 4'b1111;
    tick();
    chk("mr_ptr0", {28'b0, gnt}, 32'd1);
    tick();
    req = '0;
    tick();
    tick();

    // Illegal op, then a-1 wrap.
    prev = result;
    chk("il_prev", {24'b0, prev}, 32'd1);
    set_in(1, 3'd6, 8'd9, 8'd9);
    req = 4'b0010;
    tick();
    chk("il_gnt", {28'b0, gnt}, 32'd2);
    tick();
    chk("il_done", {28'b0, done}, 32'd2);
`ifdef CALC_SCHED_ERR_EN
    chk("il_err", {31'b0, err}, 32'd1);
    chk("il_result_held", {24'b0, result}, {24'b0, prev});
    req = '0;
    tick();
    chk("il_err_clr", {31'b0, err}, 32'd0);
`else
    chk("il_result", {24'b0, result}, 32'd0);
    req = '0;
    tick();
`endif
    tick();
    run_job("dec0", 1, 3'd5, 8'd0, 8'd0, 8'd255, 1);

    chk("onehot_viol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
